// File: rtl/wb_stage_buffered.sv
// Writeback stage: formats load data, selects it against the ALU result and passes
// rd / write-enable / branch redirect through a 2-entry elastic buffer.
// The buffer has a head register H and a skid register S.
// Valid/ready handshakes are used on both the MEM side and the consumer side.
// Optional feature: define WB_FWD_EN to add the decode-bypass ports fwd_valid/fwd_rd/fwd_data.
module wb_stage_buffered #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  localparam int AW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem_to_reg,
  input  logic [2:0]      in_funct3,
  input  logic [AW-1:0]   in_addr_lo,
  input  logic [XLEN-1:0] in_data_mem,
  input  logic [XLEN-1:0] in_result_alu,
  input  logic            in_reg_write,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_pc_src,
  input  logic [XLEN-1:0] in_branch_target,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_reg_write,
  output logic [REGW-1:0] out_rd,
  output logic            out_pc_src,
  output logic [XLEN-1:0] out_branch_target
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [REGW-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  // One buffered writeback transfer; the valid bit is kept separately.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            reg_write;
    logic [REGW-1:0] rd;
    logic            pc_src;
    logic [XLEN-1:0] target;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Load formatting (done before buffering so both entries hold final data)
  // ---------------------------------------------------------------------------
  logic [AW+2:0]   byte_off;
  logic [AW+2:0]   half_off;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [XLEN-1:0] word_sext;
  logic [XLEN-1:0] word_zext;
  logic [XLEN-1:0] load_val;

  // The byte lane uses every address bit.
  // The half lane ignores bit 0, so misaligned halves fall back to the enclosing aligned half.
  assign byte_off = {in_addr_lo, 3'b000};
  assign half_off = {in_addr_lo[AW-1:1], 4'b0000};
  assign byte_val = in_data_mem[byte_off +: 8];
  assign half_val = in_data_mem[half_off +: 16];

  generate
    if (XLEN == 64) begin : g_word64
      logic [AW+2:0] word_off;
      logic [31:0]   word_val;
      assign word_off  = {in_addr_lo[AW-1:2], 5'b00000};
      assign word_val  = in_data_mem[word_off +: 32];
      assign word_sext = {{32{word_val[31]}}, word_val};
      assign word_zext = {32'b0, word_val};
    end else begin : g_word32
      // A word already fills the datapath, so there is nothing to extend.
      // LWU therefore degenerates to passing the full word.
      assign word_sext = in_data_mem;
      assign word_zext = in_data_mem;
    end
  endgenerate

  // Select the load result by funct3 (RISC-V LOAD encoding).
  always_comb begin
    load_val = in_data_mem;
    case (in_funct3)
      3'b000:  load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
      3'b001:  load_val = {{(XLEN-16){half_val[15]}}, half_val};
      3'b010:  load_val = word_sext;
      3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_val};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, half_val};
      3'b110:  load_val = word_zext;
      default: load_val = in_data_mem;  // LD and unused encodings pass the full word
    endcase
  end

  entry_t in_entry;

  // Assemble the incoming entry from the formatted result and the control fields.
  always_comb begin
    in_entry.data      = in_mem_to_reg ? load_val : in_result_alu;
    in_entry.reg_write = in_reg_write;
    in_entry.rd        = in_rd;
    in_entry.pc_src    = in_pc_src;
    in_entry.target    = in_branch_target;
  end

  // ---------------------------------------------------------------------------
  // Two-entry elastic buffer
  // ---------------------------------------------------------------------------
  entry_t h_reg, h_next;
  entry_t s_reg, s_next;
  logic   h_valid_reg, h_valid_next;
  logic   s_valid_reg, s_valid_next;
  logic   accept;
  logic   drain;

  // in_ready is a function of registered state only.
  // This keeps the upstream stall path free of any dependence on out_ready.
  assign in_ready = ~s_valid_reg & ~rst;
  assign accept   = in_valid & in_ready;
  assign drain    = ~h_valid_reg | out_ready;

  // Next-state for head and skid.
  // On a drain, the skid entry takes priority over new input, which preserves FIFO order.
  always_comb begin
    h_next       = h_reg;
    s_next       = s_reg;
    h_valid_next = h_valid_reg;
    s_valid_next = s_valid_reg;
    if (flush) begin
      h_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (drain) begin
      if (s_valid_reg) begin
        h_next       = s_reg;
        h_valid_next = 1'b1;
        s_valid_next = 1'b0;
      end else if (accept) begin
        h_next       = in_entry;
        h_valid_next = 1'b1;
      end else begin
        h_valid_next = 1'b0;
      end
    end else if (accept) begin
      s_next       = in_entry;
      s_valid_next = 1'b1;
    end
  end

  // Buffer state registers; reset clears everything, including the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg       <= '0;
      s_reg       <= '0;
      h_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
    end else begin
      h_reg       <= h_next;
      s_reg       <= s_next;
      h_valid_reg <= h_valid_next;
      s_valid_reg <= s_valid_next;
    end
  end

  // The head drives the consumer.
  // Writes to x0 are suppressed here, so the register file never sees them.
  assign out_valid         = h_valid_reg;
  assign out_data          = h_reg.data;
  assign out_rd            = h_reg.rd;
  assign out_reg_write     = h_valid_reg & h_reg.reg_write & (h_reg.rd != '0);
  assign out_pc_src        = h_valid_reg & h_reg.pc_src;
  assign out_branch_target = h_reg.target;

`ifdef WB_FWD_EN
  // ---------------------------------------------------------------------------
  // Decode bypass: youngest buffered entry that will write a non-zero rd
  // ---------------------------------------------------------------------------
  logic s_fwd_hit;
  logic h_fwd_hit;

  assign s_fwd_hit = s_valid_reg & s_reg.reg_write & (s_reg.rd != '0);
  assign h_fwd_hit = h_valid_reg & h_reg.reg_write & (h_reg.rd != '0);

  // Skid is younger than head, so it wins; outputs are zeroed when neither hits.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (s_fwd_hit) begin
      fwd_valid = 1'b1;
      fwd_rd    = s_reg.rd;
      fwd_data  = s_reg.data;
    end else if (h_fwd_hit) begin
      fwd_valid = 1'b1;
      fwd_rd    = h_reg.rd;
      fwd_data  = h_reg.data;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Directed self-checking bench for wb_stage_buffered (XLEN=32, REGW=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wb_stage_buffered;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int AW   = 2;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_mem_to_reg;
  logic [2:0]      in_funct3;
  logic [AW-1:0]   in_addr_lo;
  logic [XLEN-1:0] in_data_mem;
  logic [XLEN-1:0] in_result_alu;
  logic            in_reg_write;
  logic [REGW-1:0] in_rd;
  logic            in_pc_src;
  logic [XLEN-1:0] in_branch_target;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_reg_write;
  logic [REGW-1:0] out_rd;
  logic            out_pc_src;
  logic [XLEN-1:0] out_branch_target;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [REGW-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  wb_stage_buffered #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_funct3        (in_funct3),
    .in_addr_lo       (in_addr_lo),
    .in_data_mem      (in_data_mem),
    .in_result_alu    (in_result_alu),
    .in_reg_write     (in_reg_write),
    .in_rd            (in_rd),
    .in_pc_src        (in_pc_src),
    .in_branch_target (in_branch_target),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_reg_write    (out_reg_write),
    .out_rd           (out_rd),
    .out_pc_src       (out_pc_src),
    .out_branch_target(out_branch_target)
`ifdef WB_FWD_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one transfer on the MEM side (held until changed).
  task automatic offer(input logic m2r, input logic [2:0] f3, input logic [AW-1:0] alo,
                       input logic [31:0] mem, input logic [31:0] alu, input logic rw,
                       input logic [4:0] rd, input logic pc, input logic [31:0] tgt);
    in_valid         = 1'b1;
    in_mem_to_reg    = m2r;
    in_funct3        = f3;
    in_addr_lo       = alo;
    in_data_mem      = mem;
    in_result_alu    = alu;
    in_reg_write     = rw;
    in_rd            = rd;
    in_pc_src        = pc;
    in_branch_target = tgt;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd);
    offer(1'b0, 3'b010, 2'd0, 32'h0, alu, 1'b1, rd, 1'b0, 32'h0);
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [AW-1:0] alo);
    offer(1'b1, f3, alo, 32'h80FF1234, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_mem_to_reg = 1'b0; in_funct3 = 3'b0; in_addr_lo = '0;
    in_data_mem = '0; in_result_alu = '0; in_reg_write = 1'b0; in_rd = '0;
    in_pc_src = 1'b0; in_branch_target = '0; flush = 1'b0; out_ready = 1'b0;

    // Initial reset
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'(1));

    // Test 1: fill H and S, then reset asynchronously mid-cycle
    alu_op(32'h11, 5'd1);
    step();
    chk("fill_h_ready", 64'(in_ready), 64'(1));
    alu_op(32'h22, 5'd2);
    step();
    chk("fill_s_ready", 64'(in_ready), 64'(0));
    chk("fill_head_data", 64'(out_data), 64'h11);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    chk("arst_out_rd", 64'(out_rd), 64'(0));
    chk("arst_reg_write", 64'(out_reg_write), 64'(0));
    chk("arst_pc_src", 64'(out_pc_src), 64'(0));
    chk("arst_target", 64'(out_branch_target), 64'(0));
    step();
    rst = 1'b0;
    step();
    chk("arst_rel_ready", 64'(in_ready), 64'(1));
    chk("arst_rel_valid", 64'(out_valid), 64'(0));

    // Test 2: ALU path
    out_ready = 1'b1;
    alu_op(32'hDEADBEEF, 5'd5);
    step();
    chk("alu_valid", 64'(out_valid), 64'(1));
    chk("alu_data", 64'(out_data), 64'hDEADBEEF);
    chk("alu_rd", 64'(out_rd), 64'd5);
    chk("alu_reg_write", 64'(out_reg_write), 64'(1));

    // Test 3: loads from 0x80FF1234, back-to-back at full throughput
    load_op(3'b000, 2'd3);
    step();
    chk("lb_a3", 64'(out_data), 64'hFFFFFF80);
    load_op(3'b101, 2'd2);
    step();
    chk("lhu_a2", 64'(out_data), 64'h000080FF);
    load_op(3'b001, 2'd0);
    step();
    chk("lh_a0", 64'(out_data), 64'h00001234);
    load_op(3'b010, 2'd0);
    step();
    chk("lw_a0", 64'(out_data), 64'h80FF1234);
    load_op(3'b100, 2'd1);
    step();
    chk("lbu_a1", 64'(out_data), 64'h00000012);
    load_op(3'b101, 2'd3);
    step();
    chk("lhu_a3_misalign", 64'(out_data), 64'h000080FF);
    load_op(3'b001, 2'd2);
    step();
    chk("lh_a2", 64'(out_data), 64'hFFFF80FF);
    load_op(3'b111, 2'd1);
    step();
    chk("f3_111_full", 64'(out_data), 64'h80FF1234);
    chk("load_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    step();
    chk("load_drained", 64'(out_valid), 64'(0));

    // Test 4: back-pressure with A, B, C offered back-to-back
    out_ready = 1'b0;
    alu_op(32'hA, 5'd10);
    step();
    chk("bp_a_ready", 64'(in_ready), 64'(1));
    chk("bp_a_head", 64'(out_data), 64'hA);
    alu_op(32'hB, 5'd11);
    step();
    chk("bp_b_ready", 64'(in_ready), 64'(0));
    alu_op(32'hC, 5'd12);
    step();
    chk("bp_c_held_ready", 64'(in_ready), 64'(0));
    chk("bp_c_held_head", 64'(out_data), 64'hA);
    step();
    chk("bp_stall_head", 64'(out_data), 64'hA);
    chk("bp_stall_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    step();
    chk("bp_b_out", 64'(out_data), 64'hB);
    chk("bp_b_rd", 64'(out_rd), 64'd11);
    chk("bp_ready_again", 64'(in_ready), 64'(1));
    step();
    chk("bp_c_out", 64'(out_data), 64'hC);
    chk("bp_c_rd", 64'(out_rd), 64'd12);
    in_valid = 1'b0;
    step();
    chk("bp_no_dup", 64'(out_valid), 64'(0));

    // Test 5: rd = 0 and branch redirect
    offer(1'b0, 3'b010, 2'd0, 32'h0, 32'h55, 1'b1, 5'd0, 1'b1, 32'h100);
    step();
    chk("rd0_valid", 64'(out_valid), 64'(1));
    chk("rd0_reg_write", 64'(out_reg_write), 64'(0));
    chk("br_pc_src", 64'(out_pc_src), 64'(1));
    chk("br_target", 64'(out_branch_target), 64'h100);
    in_valid = 1'b0;
    step();
    chk("br_pc_src_clear", 64'(out_pc_src), 64'(0));

    // Test 6: flush with H and S full plus a new input offered
    out_ready = 1'b0;
    alu_op(32'h77, 5'd7);
    step();
    alu_op(32'h88, 5'd8);
    step();
    chk("fl_full_ready", 64'(in_ready), 64'(0));
`ifdef WB_FWD_EN
    chk("fwd_pre_valid", 64'(fwd_valid), 64'(1));
    chk("fwd_pre_rd", 64'(fwd_rd), 64'd8);
    chk("fwd_pre_data", 64'(fwd_data), 64'h88);
`endif
    offer(1'b1, 3'b010, 2'd0, 32'h99, 32'h0, 1'b1, 5'd9, 1'b1, 32'h40);
    flush = 1'b1;
    chk("fl_cycle_valid", 64'(out_valid), 64'(1));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    chk("fl_pc_src", 64'(out_pc_src), 64'(0));
`ifdef WB_FWD_EN
    chk("fwd_post_valid", 64'(fwd_valid), 64'(0));
    chk("fwd_post_rd", 64'(fwd_rd), 64'(0));
`endif
    out_ready = 1'b1;
    step();
    chk("fl_nothing_out", 64'(out_valid), 64'(0));

    // Flush on an empty buffer while an input is accepted: the input is dropped.
    alu_op(32'h66, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop_input", 64'(out_valid), 64'(0));
    step();
    chk("fl_drop_later", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
